// File: rtl/program_memory_loadable_pkg.sv
// Shared definitions for the loadable program memory: FSM states, the NOP
// instruction word and the bytes-per-word derivation.
package program_memory_loadable_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Wide enough for any supported word width; users slice off DB bits.
  localparam int MAX_DB = 64;
  localparam logic [MAX_DB-1:0] NOP_WORD = '0;

  function automatic int bytes_of(input int db);
    return db / 8;
  endfunction

endpackage

// File: rtl/program_memory_loadable_if.sv
// Loader and fetch signals of the program memory, grouped as one bus.
interface program_memory_loadable_if #(
  parameter int AB = 11,
  parameter int DB = 16
);
  logic          load_start;
  logic [AB:0]   load_len;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          load_busy;
  logic          load_done;
  logic          fetch_req;
  logic [AB-1:0] Addr;
  logic          fetch_valid;
  logic [DB-1:0] Data;
  logic          fetch_err;

  modport master (
    output load_start, load_len, rx_data, rx_valid, fetch_req, Addr,
    input  load_busy, load_done, fetch_valid, Data, fetch_err
  );

  modport slave (
    input  load_start, load_len, rx_data, rx_valid, fetch_req, Addr,
    output load_busy, load_done, fetch_valid, Data, fetch_err
  );
endinterface

// File: rtl/program_memory_loadable_byte_assembler.sv
// Big-endian byte-to-word assembler: the first byte of each word ends up in
// the MSB; word_strobe marks the byte that completes a word.
module program_memory_loadable_byte_assembler
  import program_memory_loadable_pkg::*;
#(
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          shift_en,
  input  logic [7:0]    byte_in,
  output logic [DB-1:0] word,
  output logic          word_strobe
);
  localparam int BYTES = bytes_of(DB);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [CW-1:0] byte_cnt;

  // word is combinational so the completing byte is written on its own edge
  assign word_strobe = shift_en && (byte_cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      byte_cnt <= '0;
    end else if (shift_en) begin
      byte_cnt <= word_strobe ? '0 : byte_cnt + CW'(1);
    end
  end

  if (DB > 8) begin : g_multi
    logic [DB-9:0] partial;

    assign word = {partial, byte_in};

    always_ff @(posedge clk) begin
      if (clr) begin
        partial <= '0;
      end else if (shift_en) begin
        partial <= word[DB-9:0];
      end
    end
  end else begin : g_single
    assign word = byte_in;
  end

endmodule

// File: rtl/program_memory_loadable.sv
// Instruction memory with an in-system byte-stream loader and a registered,
// one-cycle-latency fetch port that returns NOP plus an error outside the program.
module program_memory_loadable
  import program_memory_loadable_pkg::*;
#(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input logic clk,
  input logic rst_n,
  program_memory_loadable_if.slave bus
);
  localparam int DEPTH = 2 ** AB;
  localparam logic [AB:0] DEPTH_W = (AB + 1)'(DEPTH);
  localparam logic [AB:0] ONE     = (AB + 1)'(1);

  state_t        state, state_n;
  logic [AB:0]   wr_ptr, len_q, loaded_words;
  logic [DB-1:0] mem [DEPTH];
  logic [DB-1:0] word;
  logic          word_strobe, start_ok, shift_en, asm_clr;
  logic          final_write, fetch_ok, in_range;
  logic          load_done_q, fetch_valid_q, fetch_err_q;
  logic [DB-1:0] data_q;

  assign start_ok    = bus.load_start && (bus.load_len != '0);
  assign shift_en    = (state == LOAD) && bus.rx_valid && !start_ok;
  assign asm_clr     = !rst_n || start_ok;
  assign final_write = word_strobe && ((wr_ptr + ONE) == len_q);
  assign in_range    = {1'b0, bus.Addr} < loaded_words;
  assign fetch_ok    = bus.fetch_req && (state != LOAD) && !start_ok;

  assign bus.load_busy   = (state == LOAD);
  assign bus.load_done   = load_done_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.Data        = data_q;

  program_memory_loadable_byte_assembler #(.DB(DB)) u_asm (
    .clk        (clk),
    .clr        (asm_clr),
    .shift_en   (shift_en),
    .byte_in    (bus.rx_data),
    .word       (word),
    .word_strobe(word_strobe)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A valid load_start always (re)enters LOAD, even from LOAD itself.
  always_comb begin
    state_n = state;
    if (start_ok) begin
      state_n = LOAD;
    end else if ((state == LOAD) && final_write) begin
      state_n = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      len_q        <= '0;
      loaded_words <= '0;
      load_done_q  <= 1'b0;
    end else begin
      load_done_q <= final_write;
      if (start_ok) begin
        wr_ptr       <= '0;
        loaded_words <= '0;
        len_q        <= (bus.load_len > DEPTH_W) ? DEPTH_W : bus.load_len;
      end else if (word_strobe) begin
        wr_ptr <= wr_ptr + ONE;
        if (final_write) loaded_words <= len_q;
      end
    end
  end

  // No reset on the array: a program survives reset but is marked invalid.
  always_ff @(posedge clk) begin
    if (word_strobe) mem[wr_ptr[AB-1:0]] <= word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      data_q        <= '0;
    end else if (fetch_ok) begin
      fetch_valid_q <= 1'b1;
      if ((state == RUN) && in_range) begin
        data_q      <= mem[bus.Addr];
        fetch_err_q <= 1'b0;
      end else begin
        data_q      <= NOP_WORD[DB-1:0];
        fetch_err_q <= 1'b1;
      end
    end else begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end
  end

endmodule
